pc_sequencer: RTL and testbench



---
 rtl/pc_seq_pkg.sv | 6 +
 rtl/pc_next_calc.sv | 16 +
 rtl/pc_sequencer.sv | 107 ++++++++++
 tb/tb_pc_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding and constants for the program-counter sequencer.
package pc_seq_pkg;
  typedef enum logic [2:0] {BOOT, FETCH, EXECUTE, HALT, ERROR} state_t;
  localparam int PC_INC = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: resolves the next PC from branch/zero and flags misaligned taken targets.
module pc_next_calc import pc_seq_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            branch_i,
  input  logic            zero_i,
  input  logic [XLEN-1:0] offset_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            sel_o,
  output logic            misaligned_o
);
  assign sel_o        = branch_i & zero_i;
  assign next_pc_o    = sel_o ? pc_i + offset_i : pc_i + XLEN'(PC_INC);
  assign misaligned_o = sel_o & |offset_i[1:0];
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC and steps fetch -> execute -> PC update,
// with a fetch-latency watchdog, halt/restart and a retired-instruction counter.
module pc_sequencer import pc_seq_pkg::*; #(
  parameter int              XLEN          = 32,
  parameter logic [XLEN-1:0] RESET_PC      = XLEN'(RESET_PC_DEF),
  parameter int              FETCH_TIMEOUT = 255,
  parameter int              TW            = 8,
  parameter int              CW            = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            fetch_ack,
  input  logic            exec_done,
  input  logic            branch,
  input  logic            zero,
  input  logic [XLEN-1:0] branch_offset,
  input  logic            halt_req,
  output logic [XLEN-1:0] pc,
  output logic            fetch_req,
  output logic            exec_en,
  output logic            taken,
  output logic [CW-1:0]   retired,
  output logic            halted,
  output logic            error
);
  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, next_pc;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   retired_q, retired_d;
  logic            taken_q, taken_d, error_q, error_d, sel, misaligned;

  pc_next_calc #(.XLEN(XLEN)) u_next (
    .pc_i(pc_q), .branch_i(branch), .zero_i(zero), .offset_i(branch_offset),
    .next_pc_o(next_pc), .sel_o(sel), .misaligned_o(misaligned)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    timer_d   = timer_q;
    retired_d = retired_q;
    taken_d   = 1'b0;
    error_d   = error_q;
    case (state_q)
      BOOT, HALT: state_d = start ? FETCH : state_q;
      FETCH: begin
        // ack on the last allowed cycle still wins over the timeout
        if (fetch_ack) begin
          state_d = EXECUTE;
          timer_d = '0;
        end else if (timer_q == TW'(FETCH_TIMEOUT - 1)) begin
          state_d = ERROR;
          error_d = 1'b1;
        end else timer_d = timer_q + TW'(1);
      end
      EXECUTE: begin
        if (exec_done) begin
          if (halt_req) begin
            pc_d      = pc_q + XLEN'(PC_INC);
            retired_d = retired_q + CW'(1);
            state_d   = HALT;
          end else if (misaligned) begin
            state_d = ERROR;
            error_d = 1'b1;
          end else begin
            pc_d      = next_pc;
            taken_d   = sel;
            retired_d = retired_q + CW'(1);
            state_d   = FETCH;
          end
        end
      end
      ERROR: state_d = ERROR;
      default: begin
        state_d = ERROR;
        error_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      timer_q   <= '0;
      retired_q <= '0;
      taken_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      timer_q   <= timer_d;
      retired_q <= retired_d;
      taken_q   <= taken_d;
      error_q   <= error_d;
    end
  end

  assign pc        = pc_q;
  assign taken     = taken_q;
  assign retired   = retired_q;
  assign error     = error_q;
  assign fetch_req = state_q == FETCH;
  assign exec_en   = state_q == EXECUTE;
  assign halted    = state_q == HALT;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench; a small reference model predicts each
// retirement when exec_done is driven and the result is checked one edge later.
module tb_pc_sequencer;
  localparam int FT = 6;
  logic        clk = 0, rst_n = 0, start = 0, fetch_ack = 0, exec_done = 0;
  logic        branch = 0, zero = 0, halt_req = 0;
  logic [31:0] branch_offset = 0, pc;
  logic        fetch_req, exec_en, taken, halted, error;
  logic [3:0]  retired;
  int          checks = 0, errors = 0;
  logic [31:0] m_pc;
  logic [3:0]  m_ret;
  typedef struct packed {logic [31:0] pc; logic tk; logic [3:0] ret; logic hl; logic er;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pc_sequencer #(.XLEN(32), .RESET_PC(32'h0), .FETCH_TIMEOUT(FT), .TW(3), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fetch_ack(fetch_ack), .exec_done(exec_done),
    .branch(branch), .zero(zero), .branch_offset(branch_offset), .halt_req(halt_req),
    .pc(pc), .fetch_req(fetch_req), .exec_en(exec_en), .taken(taken), .retired(retired),
    .halted(halted), .error(error)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 0;
    #2;
    rst_n = 1;
    m_pc = 0;
    m_ret = 0;
    tick();
  endtask

  task automatic do_start;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic exec_instr(input logic br, input logic z, input logic h, input logic [31:0] off);
    exp_t e, a;
    fetch_ack = 1;
    tick();
    fetch_ack = 0;
    checks++;
    if (exec_en !== 1'b1 || fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL exec_stage exec_en=%b fetch_req=%b expected 1/0", exec_en, fetch_req);
    end
    exec_done = 1; branch = br; zero = z; halt_req = h; branch_offset = off;
    e = '{pc: m_pc, tk: 1'b0, ret: m_ret, hl: 1'b0, er: 1'b0};
    if (h) begin
      e.pc = m_pc + 32'd4; e.ret = m_ret + 4'd1; e.hl = 1'b1;
    end else if (br && z && off[1:0] != 2'b00) e.er = 1'b1;
    else begin
      e.pc = (br && z) ? m_pc + off : m_pc + 32'd4;
      e.tk = br && z;
      e.ret = m_ret + 4'd1;
    end
    m_pc = e.pc;
    m_ret = e.ret;
    sb.push_back(e);
    tick();
    exec_done = 0; branch = 0; zero = 0; halt_req = 0;
    a = sb.pop_front();
    checks++;
    if ({pc, taken, retired, halted, error} !== a) begin
      errors++;
      $display("FAIL retire pc=%h tk=%b ret=%0d hl=%b er=%b expected pc=%h tk=%b ret=%0d hl=%b er=%b",
               pc, taken, retired, halted, error, a.pc, a.tk, a.ret, a.hl, a.er);
    end
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({pc, fetch_req, exec_en, taken, retired, halted, error} !== 41'h0) begin
      errors++;
      $display("FAIL reset pc=%h req=%b en=%b tk=%b ret=%0d hl=%b er=%b expected all zero",
               pc, fetch_req, exec_en, taken, retired, halted, error);
    end
  endtask

  task automatic test_ignore;
    fetch_ack = 1; exec_done = 1;
    tick();
    fetch_ack = 0;
    checks++;
    if (fetch_req !== 1'b0 || pc !== 32'h0) begin
      errors++;
      $display("FAIL boot_ignore fetch_req=%b pc=%h expected 0/0", fetch_req, pc);
    end
    exec_done = 0;
    do_start();
    exec_done = 1;
    tick();
    exec_done = 0;
    checks++;
    if (fetch_req !== 1'b1 || pc !== 32'h0 || retired !== 4'd0) begin
      errors++;
      $display("FAIL fetch_ignore fetch_req=%b pc=%h ret=%0d expected 1/0/0", fetch_req, pc, retired);
    end
  endtask

  task automatic test_sequential;
    for (int i = 0; i < 3; i++) exec_instr(0, 0, 0, 0);
  endtask

  task automatic test_branch;
    exec_instr(0, 0, 0, 0);
    exec_instr(1, 1, 0, 32'hFFFF_FFF8);
    tick();
    checks++;
    if (taken !== 1'b0 || pc !== 32'h8) begin
      errors++;
      $display("FAIL taken_pulse taken=%b pc=%h expected 0/00000008", taken, pc);
    end
    exec_instr(0, 0, 0, 0);
    exec_instr(0, 0, 0, 0);
    exec_instr(1, 0, 0, 32'hFFFF_FFF8);
  endtask

  task automatic test_halt;
    for (int i = 0; i < 3; i++) exec_instr(0, 0, 0, 0);
    exec_instr(1, 1, 1, 32'hFFFF_FFF8);
    do_start();
    checks++;
    if (fetch_req !== 1'b1 || halted !== 1'b0 || pc !== 32'h24) begin
      errors++;
      $display("FAIL restart req=%b halted=%b pc=%h expected 1/0/00000024", fetch_req, halted, pc);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    do_start();
    repeat (FT - 1) tick();
    checks++;
    if (fetch_req !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL pre_timeout req=%b err=%b expected 1/0", fetch_req, error);
    end
    tick();
    checks++;
    if (fetch_req !== 1'b0 || error !== 1'b1) begin
      errors++;
      $display("FAIL timeout req=%b err=%b expected 0/1", fetch_req, error);
    end
    start = 1; fetch_ack = 1; exec_done = 1;
    repeat (3) tick();
    start = 0; fetch_ack = 0; exec_done = 0;
    checks++;
    if ({fetch_req, exec_en, halted, error} !== 4'b0001) begin
      errors++;
      $display("FAIL error_sticky req=%b en=%b hl=%b err=%b expected 0/0/0/1", fetch_req, exec_en, halted, error);
    end
    do_reset();
    do_start();
    repeat (FT - 1) tick();
    fetch_ack = 1;
    tick();
    fetch_ack = 0;
    checks++;
    if (exec_en !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL ack_last_cycle en=%b err=%b expected 1/0", exec_en, error);
    end
  endtask

  task automatic test_misaligned;
    do_reset();
    do_start();
    exec_instr(0, 0, 0, 0);
    exec_instr(0, 0, 0, 0);
    exec_instr(1, 1, 0, 32'h6);
    do_reset();
    do_start();
    exec_instr(0, 0, 0, 0);
    exec_instr(0, 0, 0, 0);
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({pc, fetch_req, exec_en, taken, retired, halted, error} !== 41'h0) begin
      errors++;
      $display("FAIL async_reset pc=%h req=%b en=%b tk=%b ret=%0d hl=%b er=%b expected all zero",
               pc, fetch_req, exec_en, taken, retired, halted, error);
    end
    #1;
    rst_n = 1;
  endtask

  task automatic test_wrap;
    do_reset();
    do_start();
    exec_instr(1, 1, 0, 32'hFFFF_FFFC);
    exec_instr(0, 0, 0, 0);
    for (int i = 0; i < 14; i++) exec_instr(0, 0, 0, 0);
    checks++;
    if (retired !== 4'd0 || error !== 1'b0) begin
      errors++;
      $display("FAIL retired_wrap ret=%0d err=%b expected 0/0", retired, error);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ignore();
    test_sequential();
    test_branch();
    test_halt();
    test_timeout();
    test_misaligned();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
